// File: rtl/imm_pkg.sv
// imm_pkg: immediate format encodings, RV32 opcode constants and result record for imm_gen_pipe
package imm_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam int XLEN_MAX = 64;
  localparam int TAG_MAX  = 16;
  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    logic                illegal;
    logic [TAG_MAX-1:0]  tag;
  } imm_res_t;
  // unknown opcodes map to an encoding outside the enum so the extractor flags them illegal
  function automatic imm_sel_e sel_from_opcode(input logic [6:0] op);
    return (op == OP_IMM || op == OP_LOAD || op == OP_JALR || op == OP_SYSTEM) ? IMM_I :
           (op == OP_STORE)                    ? IMM_S :
           (op == OP_BRANCH)                   ? IMM_B :
           (op == OP_LUI || op == OP_AUIPC)    ? IMM_U :
           (op == OP_JAL)                      ? IMM_J : imm_sel_e'(3'd7);
  endfunction
endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational RISC-V immediate extraction and sign extension to XLEN
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_sel_e        sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  logic [31:0] raw;
  always_comb begin
    raw = (sel == IMM_I) ? {{20{instr[31]}}, instr[31:20]} :
          (sel == IMM_S) ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
          (sel == IMM_B) ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
          (sel == IMM_U) ? {instr[31:12], 12'b0} :
          (sel == IMM_J) ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
                           32'd0;
    illegal = sel > IMM_J;
    imm = XLEN'(signed'(raw));
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate generator with a one-cycle output register and a one-entry skid buffer
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 5,
  parameter bit AUTO_SEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  imm_sel_e         in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } ent_t;
  imm_sel_e        sel;
  logic [XLEN-1:0] ext_imm;
  logic            ext_illegal;
  ent_t            res, out_q, out_d, skid_q, skid_d;
  logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, ready_q;
  logic            accept, drain, load_out;
  assign sel = AUTO_SEL ? sel_from_opcode(in_instr[6:0]) : in_sel;
  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr  (in_instr[31:7]),
    .sel    (sel),
    .imm    (ext_imm),
    .illegal(ext_illegal)
  );
  assign res      = {ext_imm, ext_illegal, in_tag};
  assign accept   = in_valid && ready_q;
  assign drain    = out_valid_q && out_ready;
  assign load_out = !out_valid_q || drain;
  // the skid is always older than a new arrival, so it refills the output first
  always_comb begin
    out_d        = !load_out ? out_q : skid_valid_q ? skid_q : accept ? res : out_q;
    out_valid_d  = !load_out || skid_valid_q || accept;
    skid_valid_d = load_out ? (skid_valid_q && accept) : (skid_valid_q || accept);
    skid_d       = (accept && (skid_valid_q || !load_out)) ? res : skid_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
  end
  assign in_ready    = ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_illegal = out_q.illegal;
  assign out_tag     = out_q.tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: vector table plus scoreboard check of imm_gen_pipe in three configurations
module tb_imm_gen_pipe;
  import imm_pkg::*;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic        in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0;
  imm_sel_e    in_sel = IMM_I;
  logic [4:0]  in_tag = 0;
  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, il0, il1, il2;
  logic [31:0] im0, im1;
  logic [63:0] im2;
  logic [4:0]  tg0, tg1, tg2;
  imm_gen_pipe u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_instr(in_instr),
    .in_sel(in_sel), .in_tag(in_tag), .out_valid(ov0), .out_ready(out_ready), .out_imm(im0),
    .out_illegal(il0), .out_tag(tg0));
  imm_gen_pipe #(.AUTO_SEL(1'b1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(ov1), .out_ready(out_ready),
    .out_imm(im1), .out_illegal(il1), .out_tag(tg1));
  imm_gen_pipe #(.XLEN(64), .AUTO_SEL(1'b1)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(rdy2), .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(ov2),
    .out_ready(out_ready), .out_imm(im2), .out_illegal(il2), .out_tag(tg2));
  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] e_sel;
    logic        l_sel;
    logic [63:0] e_auto;
    logic        l_auto;
  } vec_t;
  typedef struct {
    logic [31:0] i0;
    logic        l0;
    logic [63:0] ia;
    logic        la;
    logic [4:0]  tag;
  } exp_t;
  int total = 0, bad = 0;
  vec_t tbl[16];
  exp_t cur, q[$];
  logic rnd = 0;
  logic [6:0] ops[9] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] s, output logic ill);
    ill = 1'b0;
    case (s)
      3'd0: return {{52{w[31]}}, w[31:20]};
      3'd1: return {{52{w[31]}}, w[31:25], w[11:7]};
      3'd2: return {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3: return {{32{w[31]}}, w[31:12], 12'b0};
      3'd4: return {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: begin ill = 1'b1; return 64'd0; end
    endcase
  endfunction
  function automatic logic [2:0] ref_auto(input logic [6:0] op);
    case (op)
      7'h13, 7'h03, 7'h67, 7'h73: return 3'd0;
      7'h23: return 3'd1;
      7'h63: return 3'd2;
      7'h37, 7'h17: return 3'd3;
      7'h6f: return 3'd4;
      default: return 3'd7;
    endcase
  endfunction
  function automatic vec_t mk_rand();
    vec_t v;
    logic [63:0] e;
    v.instr = $urandom;
    if ($urandom_range(0, 3) != 0) v.instr[6:0] = ops[$urandom_range(0, 8)];
    v.sel = 3'($urandom_range(0, 7));
    e = ref_imm(v.instr, v.sel, v.l_sel);
    v.e_sel = e[31:0];
    v.e_auto = ref_imm(v.instr, ref_auto(v.instr[6:0]), v.l_auto);
    return v;
  endfunction
  task automatic drive(input vec_t v, input logic [4:0] tag);
    in_instr = v.instr;
    in_sel = imm_sel_e'(v.sel);
    in_tag = tag;
    cur = '{v.e_sel, v.l_sel, v.e_auto, v.l_auto, tag};
    in_valid = 1;
  endtask
  task automatic send(input vec_t v, input logic [4:0] tag);
    logic acc = 0;
    int n = 0;
    drive(v, tag);
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = rdy0;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 0;
    chk("accept_timeout", 64'(acc), 64'd1);
  endtask
  logic hold = 0;
  logic [31:0] h_im;
  logic [4:0] h_tg;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      hold = 0;
    end else begin
      if (hold && ov0) begin
        chk("hold_imm", 64'(im0), 64'(h_im));
        chk("hold_tag", 64'(tg0), 64'(h_tg));
      end
      if (ov0 && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got tag %0h expected no output at %0t", tg0, $time);
        end else begin
          e = q.pop_front();
          chk("imm_sel32", 64'(im0), 64'(e.i0));
          chk("ill_sel32", 64'(il0), 64'(e.l0));
          chk("tag", 64'(tg0), 64'(e.tag));
          chk("imm_auto32", 64'(im1), 64'(e.ia[31:0]));
          chk("ill_auto32", 64'(il1), 64'(e.la));
          chk("tag_auto32", 64'(tg1), 64'(e.tag));
          chk("imm_auto64", im2, e.ia);
          chk("ill_auto64", 64'(il2), 64'(e.la));
          chk("valid_auto64", 64'(ov2 && ov1 && tg2 == e.tag), 64'd1);
        end
      end
      hold = ov0 && !out_ready;
      h_im = im0;
      h_tg = tg0;
      if (in_valid && rdy0) q.push_back(cur);
    end
  end
  always @(posedge clk) if (rnd) begin
    #1;
    out_ready = 1'($urandom_range(0, 1));
  end
  initial begin
    int n;
    tbl[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tbl[1]  = '{32'hFE20AE23, 3'd1, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    tbl[2]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    tbl[3]  = '{32'hFF9FF06F, 3'd4, 32'hFFFFFFF8, 1'b0, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    tbl[4]  = '{32'h123450B7, 3'd3, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0};
    tbl[5]  = '{32'h800000B7, 3'd3, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0};
    tbl[6]  = '{32'h000000B3, 3'd0, 32'h00000000, 1'b0, 64'h0, 1'b1};
    tbl[7]  = '{32'hFFF00093, 3'd7, 32'h00000000, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tbl[8]  = '{32'h123450B7, 3'd5, 32'h00000000, 1'b1, 64'h0000000012345000, 1'b0};
    tbl[9]  = '{32'h80002003, 3'd0, 32'hFFFFF800, 1'b0, 64'hFFFFFFFFFFFFF800, 1'b0};
    tbl[10] = '{32'h7FF00067, 3'd0, 32'h000007FF, 1'b0, 64'h7FF, 1'b0};
    tbl[11] = '{32'h30200073, 3'd0, 32'h00000302, 1'b0, 64'h302, 1'b0};
    tbl[12] = '{32'hFFFFF017, 3'd3, 32'hFFFFF000, 1'b0, 64'hFFFFFFFFFFFFF000, 1'b0};
    tbl[13] = '{32'h7E000FA3, 3'd1, 32'h000007FF, 1'b0, 64'h7FF, 1'b0};
    tbl[14] = '{32'h00000863, 3'd2, 32'h00000010, 1'b0, 64'h10, 1'b0};
    tbl[15] = '{32'hFE000EE3, 3'd6, 32'h00000000, 1'b1, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(ov0), 64'd0);
    chk("rst_in_ready", 64'(rdy0), 64'd0);
    chk("rst_imm", 64'(im0), 64'd0);
    chk("rst_tag", 64'(tg0), 64'd0);
    chk("rst_illegal", 64'(il0), 64'd0);
    rst = 0;
    chk("ready_low_after_release", 64'(rdy0), 64'd0);
    @(posedge clk);
    #1;
    chk("ready_rises", 64'(rdy0), 64'd1);
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      send(tbl[i], 5'(i));
      chk("latency", 64'(ov0), 64'd1);
    end
    repeat (2) @(posedge clk);
    #1;
    out_ready = 0;
    drive(tbl[0], 5'd1);
    @(posedge clk);
    #1;
    drive(tbl[1], 5'd2);
    @(posedge clk);
    #1;
    drive(tbl[2], 5'd3);
    chk("bp_ready_drop", 64'(rdy0), 64'd0);
    chk("bp_head_tag", 64'(tg0), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_ready_held", 64'(rdy0), 64'd0);
    chk("bp_valid_held", 64'(ov0), 64'd1);
    chk("bp_tag_held", 64'(tg0), 64'd1);
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("bp_order2", 64'(tg0), 64'd2);
    chk("bp_ready_back", 64'(rdy0), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 0;
    chk("bp_order3", 64'(tg0), 64'd3);
    chk("bp_no_gap", 64'(ov0), 64'd1);
    @(posedge clk);
    #1;
    chk("bp_empty", 64'(ov0), 64'd0);
    out_ready = 0;
    send(tbl[3], 5'd10);
    send(tbl[4], 5'd11);
    chk("full_ready_low", 64'(rdy0), 64'd0);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", 64'(ov0), 64'd0);
    chk("async_rst_ready", 64'(rdy0), 64'd0);
    chk("async_rst_imm", 64'(im0), 64'd0);
    chk("async_rst_tag", 64'(tg0), 64'd0);
    @(posedge clk);
    #1;
    rst = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("rst2_ready_rises", 64'(rdy0), 64'd1);
    chk("rst2_no_stale", 64'(ov0), 64'd0);
    send(tbl[5], 5'd20);
    chk("rst2_first_tag", 64'(tg0), 64'd20);
    chk("rst2_first_imm", 64'(im0), 64'h80000000);
    @(posedge clk);
    #1;
    rnd = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(mk_rand(), 5'(k));
    end
    rnd = 0;
    @(posedge clk);
    #1;
    out_ready = 1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 or 64.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag carried with each instruction.
REQ-003 SHALL have parameter AUTO_SEL, default 0; 1 = format derived from opcode, 0 = format taken from in_sel.
REQ-004 SHALL have the following ports: clk input 1, sole clock, rising edge.
REQ-005 rst input 1, reset, asynchronous, active-high.
REQ-006 in_valid input 1, instruction present.
REQ-007 in_ready output 1, block can accept.
REQ-008 in_instr input 32, instruction word.
REQ-009 in_sel input imm_sel_e (3 bits), format select; ignored when AUTO_SEL=1.
REQ-010 in_tag input TAG_W, sideband tag.
REQ-011 out_valid output 1, result present.
REQ-012 out_ready input 1, consumer accepts.
REQ-013 out_imm output XLEN, sign-extended immediate.
REQ-014 out_illegal output 1, format unknown.
REQ-015 out_tag output TAG_W, tag of the result.

Function
REQ-016 Input transfer SHALL occur on a clock edge with in_valid && in_ready; output transfer SHALL occur on a clock edge with out_valid && out_ready.
REQ-017 Latency SHALL be one cycle: an instruction accepted at edge N SHALL appear on out_* after edge N if the output stage is empty or is drained at edge N.
REQ-018 Formats, sign-extended from bit 31 to XLEN: I = instr[31:20]; S = {instr[31:25], instr[11:7]}; B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}; U = {instr[31:12], 12'b0}; J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-019 Unknown selection SHALL give out_imm = 0 and out_illegal = 1. Every legal format SHALL give out_illegal = 0.
REQ-020 With AUTO_SEL=1, opcode instr[6:0] SHALL map as follows: 0010011, 0000011, 1100111, 1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; any other -> illegal.
REQ-021 Buffering SHALL be a two-entry skid: an output register plus one skid register. in_ready SHALL be driven from a register as !skid_valid.
REQ-022 Accept while out_valid && !out_ready SHALL write the skid register. in_ready SHALL drop in the next cycle.
REQ-023 Output drain with skid valid SHALL move the skid into the output register and clear skid_valid. A simultaneous accept SHALL then have both entries in use, with order preserved.
REQ-024 Output drain with skid empty and a simultaneous accept SHALL load the new result directly into the output register. out_valid SHALL stay 1.
REQ-025 Output drain with no accept and skid empty SHALL clear out_valid.
REQ-026 Results SHALL leave in acceptance order. No entry SHALL be lost or duplicated under any in_valid/out_ready pattern.
REQ-027 out_imm, out_illegal and out_tag SHALL remain stable while out_valid && !out_ready.

Reset
REQ-028 rst asserted SHALL immediately force out_valid=0, skid_valid=0, in_ready=0, out_imm=0, out_illegal=0, out_tag=0, regardless of the clock.
REQ-029 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-030 Reset mid-operation SHALL discard all buffered entries, and no stale result SHALL appear afterwards.

Structure
REQ-031 Package imm_pkg SHALL hold: enum imm_sel_e with IMM_I=0, IMM_S=1, IMM_B=2, IMM_U=3, IMM_J=4; opcode constants; a packed struct of imm, illegal and tag.
REQ-032 Combinational extraction SHALL live in sub-module imm_extract (instr, sel -> imm, illegal), parametrised by XLEN. imm_gen_pipe SHALL instantiate it once ahead of the skid stage.

Verification
REQ-033 I, AUTO_SEL=0, out_ready=1: 0xFFF00093 -> out_imm 0xFFFFFFFF one cycle later. S: 0xFE20AE23 -> 0xFFFFFFFC.
REQ-034 B: 0xFE000EE3 -> 0xFFFFFFFC. J: 0xFF9FF06F -> 0xFFFFFFF8. AUTO_SEL=1 with in_sel held at garbage SHALL give the same values.
REQ-035 U: 0x123450B7 -> 0x12345000. With XLEN=64, 0x800000B7 -> 0xFFFFFFFF80000000.
REQ-036 AUTO_SEL=1 with opcode 0110011 -> out_illegal=1, out_imm=0. AUTO_SEL=0 with in_sel=7 -> same.
REQ-037 Backpressure: out_ready=0 and three back-to-back instructions with tags 1, 2, 3 -> two accepted and in_ready=0 from the second cycle; after out_ready=1, tags 1, 2, 3 leave in order with no gaps.
REQ-038 rst pulsed with both entries full -> out_valid=0 with no clock edge; after release, first output equals the first post-reset input.
